// File: rtl/hex_scan_driver_if.sv
// Display-side bundle for hex_scan_driver: value/update/mask/blank in, segment/grid/frame_done out.
// No handshake: the driver accepts inputs every cycle and never stalls.
interface hex_scan_driver_if;
    logic [15:0] value;
    logic        update;
    logic [3:0]  dp_mask;
    logic        blank;
    logic [7:0]  hex_seg;
    logic [3:0]  hex_grid;
    logic        frame_done;

    modport master (
        output value, update, dp_mask, blank,
        input  hex_seg, hex_grid, frame_done
    );

    modport slave (
        input  value, update, dp_mask, blank,
        output hex_seg, hex_grid, frame_done
    );
endinterface

// File: rtl/hex_scan_driver.sv
// 4-digit active-low 7-seg scanner, frame-aligned shadow commit, dead cycle per slot; HEX_LZB_EN adds leading-zero blanking.
// Outputs registered (1 cycle after state); no backpressure, update accepted on any cycle.
module hex_scan_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic            Clk,
    input  logic            Reset,
    hex_scan_driver_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic [1:0]    digit_idx;
    logic [15:0]   shadow;
    logic [15:0]   disp;
    logic          pending;
    logic          wrapped;
    logic          slot_end;
    logic          frame_end;
    logic [3:0]    nibble;
    logic [6:0]    seg7;
    logic          lead_zero;

    function automatic logic [6:0] encode(input logic [3:0] n);
        case (n)
            4'h0: encode = 7'h40;
            4'h1: encode = 7'h79;
            4'h2: encode = 7'h24;
            4'h3: encode = 7'h30;
            4'h4: encode = 7'h19;
            4'h5: encode = 7'h12;
            4'h6: encode = 7'h02;
            4'h7: encode = 7'h78;
            4'h8: encode = 7'h00;
            4'h9: encode = 7'h10;
            4'hA: encode = 7'h08;
            4'hB: encode = 7'h03;
            4'hC: encode = 7'h46;
            4'hD: encode = 7'h21;
            4'hE: encode = 7'h06;
            default: encode = 7'h0E;
        endcase
    endfunction

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (digit_idx == 2'd3);
    assign nibble    = disp[{digit_idx, 2'b00} +: 4];
    assign seg7      = encode(nibble);

`ifdef HEX_LZB_EN
    // A digit is dark only while it and every higher digit are zero; digit 0 always lights.
    always_comb begin
        lead_zero = 1'b0;
        case (digit_idx)
            2'd3:    lead_zero = (disp[15:12] == 4'h0);
            2'd2:    lead_zero = (disp[15:8] == 8'h00);
            2'd1:    lead_zero = (disp[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
    end
`else
    assign lead_zero = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt        <= '0;
            digit_idx      <= 2'd0;
            shadow         <= 16'h0000;
            disp           <= 16'h0000;
            pending        <= 1'b0;
            wrapped        <= 1'b0;
            bus.hex_grid   <= 4'hF;
            bus.hex_seg    <= 8'hFF;
            bus.frame_done <= 1'b0;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end)
                digit_idx <= digit_idx + 2'd1;

            // wrapped marks the cycle after the 3->0 wrap, i.e. the digit-0 dead cycle
            wrapped        <= frame_end;
            bus.frame_done <= wrapped;

            if (bus.update)
                shadow <= bus.value;
            if (frame_end) begin
                if (bus.update)
                    disp <= bus.value;
                else if (pending)
                    disp <= shadow;
                pending <= 1'b0;
            end else if (bus.update) begin
                pending <= 1'b1;
            end

            if (bus.blank || div_cnt == '0) begin
                bus.hex_grid <= 4'hF;
                bus.hex_seg  <= 8'hFF;
            end else begin
                bus.hex_grid <= ~(4'b0001 << digit_idx);
                bus.hex_seg  <= {~bus.dp_mask[digit_idx], lead_zero ? 7'h7F : seg7};
            end
        end
    end
endmodule

// File: tb/tb_hex_scan_driver.sv
// Randomised scoreboard bench for hex_scan_driver: a cycle-indexed reference model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_hex_scan_driver;
    localparam int R = 4;
    localparam int FRAME = 4 * R;
    localparam logic [6:0] ENC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [7:0] seg;
        logic [3:0] grid;
        logic       fd;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    hex_scan_driver_if bus ();

    hex_scan_driver #(.REFRESH_DIV(R)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int   checks = 0;
    int   fails  = 0;
    exp_t q[$];

    // Reference model state: n counts clock edges since reset released.
    int          n = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    bit          m_pend = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin : model
        exp_t e;
        int   pos;
        int   dig;
        logic [3:0] nib;
        logic [6:0] s7;
        forever begin
            @(posedge Clk);
            if (Reset) begin
                e = '{seg: 8'hFF, grid: 4'hF, fd: 1'b0};
                n = 0;
                m_disp = 16'h0;
                m_shadow = 16'h0;
                m_pend = 1'b0;
            end else begin
                pos = n % R;
                dig = (n / R) % 4;
                e.fd = (pos == 0) && (dig == 0) && (n > 0);
                if (pos == 0 || bus.blank) begin
                    e.seg  = 8'hFF;
                    e.grid = 4'hF;
                end else begin
                    e.grid = 4'hF;
                    e.grid[dig] = 1'b0;
                    nib = 4'(m_disp >> (4 * dig));
                    s7 = ENC[nib];
`ifdef HEX_LZB_EN
                    if (dig > 0 && (m_disp >> (4 * dig)) == 16'h0)
                        s7 = 7'h7F;
`endif
                    e.seg = {~bus.dp_mask[dig], s7};
                end
                if ((n + 1) % FRAME == 0) begin
                    if (bus.update)
                        m_disp = bus.value;
                    else if (m_pend)
                        m_disp = m_shadow;
                    m_pend = 1'b0;
                end else if (bus.update) begin
                    m_shadow = bus.value;
                    m_pend = 1'b1;
                end
                n++;
            end
            q.push_back(e);
        end
    end

    int cyc_cnt = 0;
    int last_fd = -1;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            cyc_cnt++;
            if (Reset)
                last_fd = -1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("hex_seg", {8'h0, bus.hex_seg}, {8'h0, e.seg});
                check("hex_grid", {12'h0, bus.hex_grid}, {12'h0, e.grid});
                check("frame_done", {15'h0, bus.frame_done}, {15'h0, e.fd});
                check("grid_onehot", {15'h0, ($countones(~bus.hex_grid) <= 1)}, 16'h1);
                if (bus.frame_done === 1'b1 && !Reset) begin
                    if (last_fd >= 0)
                        check("frame_period", 16'(cyc_cnt - last_fd), 16'(FRAME));
                    last_fd = cyc_cnt;
                end
            end
        end
    end

    task automatic cyc(input int k = 1);
        repeat (k) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int ph);
        int guard = 0;
        while (n % FRAME != ph && guard < 2 * FRAME) begin
            cyc();
            guard++;
        end
    endtask

    task automatic pulse_update(input logic [15:0] v);
        bus.value = v;
        bus.update = 1'b1;
        cyc();
        bus.update = 1'b0;
    endtask

    initial begin : stim
        Reset = 1'b1;
        bus.value = 16'h0;
        bus.update = 1'b0;
        bus.dp_mask = 4'h0;
        bus.blank = 1'b0;
        cyc(3);
        Reset = 1'b0;
        cyc(6);

        pulse_update(16'h07C5);
        cyc(2 * FRAME);
        cyc(3 * FRAME);

        wait_phase(5);
        pulse_update(16'hAAAA);
        wait_phase(FRAME - 1);
        pulse_update(16'h1234);
        cyc(2 * FRAME);

        bus.dp_mask = 4'b0001;
        pulse_update(16'h0005);
        cyc(2 * FRAME);
        bus.blank = 1'b1;
        cyc(20);
        bus.blank = 1'b0;
        cyc(FRAME);

        wait_phase(3);
        pulse_update(16'hFFFF);
        cyc(4);
        Reset = 1'b1;
        cyc(2);
        Reset = 1'b0;
        cyc(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            bus.update = ($urandom_range(0, 5) == 0);
            bus.value = 16'($urandom);
            if ($urandom_range(0, 15) == 0)
                bus.dp_mask = 4'($urandom);
            if ($urandom_range(0, 40) == 0)
                bus.blank = ~bus.blank;
            Reset = ($urandom_range(0, 300) == 0);
            cyc();
        end
        Reset = 1'b0;
        bus.update = 1'b0;
        bus.blank = 1'b0;
        cyc(3);
        @(negedge Clk);
        #1;
        check("queue_drained", 16'(q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
